// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS-subset control unit:
// FSM states, opcode/funct constants and datapath mux encodings.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_MUL = 6'b100001;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_MUL = 3'b011;
  localparam logic [2:0] ALU_BAD = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_alu_decoder.sv
// R-type funct field to ALU operation code; unknown functs map to ALU_BAD
// so the instruction still completes but the result is recognisably bogus.
module mc_alu_decoder
  import mc_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_BAD;
    case (funct)
      FN_ADD:  alu_control = ALU_ADD;
      FN_MUL:  alu_control = ALU_MUL;
      FN_SUB:  alu_control = ALU_SUB;
      FN_AND:  alu_control = ALU_AND;
      FN_OR:   alu_control = ALU_OR;
      FN_SLT:  alu_control = ALU_SLT;
      default: alu_control = ALU_BAD;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle sequencer: Moore FSM driving the shared-memory/shared-ALU
// datapath, with memory-ready stalls and a retired-instruction counter.
module mc_control_unit
  import mc_pkg::*;
#(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          op,
  input  logic [5:0]          funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                iord,
  output logic                mem_write,
  output logic                mem_req,
  output logic                ir_write,
  output logic                pc_en,
  output logic [1:0]          pc_src,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [2:0]          alu_control,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                illegal_op,
  output logic [RETIRE_W-1:0] retired
);

  state_t     state, next_state;
  logic       pc_write, branch, retire;
  logic [2:0] funct_alu;

  mc_alu_decoder u_alu_decoder (
    .funct       (funct),
    .alu_control (funct_alu)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= FETCH;
      retired <= '0;
    end else begin
      state <= next_state;
      if (retire) retired <= retired + RETIRE_W'(1);
    end
  end

  always_comb begin
    next_state  = state;
    iord        = 1'b0;
    mem_write   = 1'b0;
    mem_req     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    branch      = 1'b0;
    pc_src      = PCSRC_ALU;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_REG;
    alu_control = ALU_ADD;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    illegal_op  = 1'b0;
    retire      = 1'b0;
    case (state)
      FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          next_state = DECODE;
        end
      end
      // Branch target is precomputed here while the register file is read.
      DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        case (op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYPE:     next_state = EXECUTE;
          OP_BEQ:       next_state = BRANCH;
          OP_ADDI:      next_state = ADDIEXEC;
          OP_J:         next_state = JUMP;
          default: begin
            illegal_op = 1'b1;
            next_state = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        next_state = (op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) next_state = MEMWB;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        next_state = FETCH;
      end
      MEMWR: begin
        mem_req   = 1'b1;
        iord      = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) begin
          retire     = 1'b1;
          next_state = FETCH;
        end
      end
      EXECUTE: begin
        alu_src_a   = 1'b1;
        alu_control = funct_alu;
        next_state  = ALUWB;
      end
      ALUWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        retire     = 1'b1;
        next_state = FETCH;
      end
      BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        branch      = 1'b1;
        pc_src      = PCSRC_ALUOUT;
        retire      = 1'b1;
        next_state  = FETCH;
      end
      ADDIEXEC: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        next_state = ADDIWB;
      end
      ADDIWB: begin
        reg_write  = 1'b1;
        retire     = 1'b1;
        next_state = FETCH;
      end
      JUMP: begin
        pc_src     = PCSRC_JUMP;
        pc_write   = 1'b1;
        retire     = 1'b1;
        next_state = FETCH;
      end
      default: next_state = FETCH;
    endcase
    pc_en = pc_write | (branch & zero);
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench for mc_control_unit: stimulus queues expected per-cycle
// outputs, a negedge monitor pops and compares them against the DUT.
module tb_mc_control_unit;
  import mc_pkg::*;

  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    op, funct;
  logic          zero, mem_ready;
  logic          iord, mem_write, mem_req, ir_write, pc_en;
  logic [1:0]    pc_src, alu_src_b;
  logic          alu_src_a;
  logic [2:0]    alu_control;
  logic          reg_write, reg_dst, mem_to_reg, illegal_op;
  logic [RW-1:0] retired;

  mc_control_unit #(.RETIRE_W(RW)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .iord(iord), .mem_write(mem_write),
    .mem_req(mem_req), .ir_write(ir_write), .pc_en(pc_en), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .illegal_op(illegal_op), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [16:0]   o;
    logic [RW-1:0] ret;
    logic [15:0]   tag;
  } exp_t;

  exp_t          q[$];
  exp_t          mon_e;
  int            n_checks = 0;
  int            n_pass   = 0;
  int            tag      = 0;
  logic [RW-1:0] exp_ret;

  wire [16:0] act = {iord, mem_write, mem_req, ir_write, pc_en, pc_src,
                     alu_src_a, alu_src_b, alu_control, reg_write, reg_dst,
                     mem_to_reg, illegal_op};

  // Field order: iord,mem_write,mem_req,ir_write,pc_en,pc_src[2],alu_src_a,
  // alu_src_b[2],alu_control[3],reg_write,reg_dst,mem_to_reg,illegal_op
  function automatic logic [16:0] expv(state_t s, logic [5:0] o, logic [5:0] f,
                                       logic z, logic mr);
    logic iw, mw, mq, irw, pe, sa, rw, rd, m2r, ill;
    logic [1:0] ps, sb;
    logic [2:0] ac;
    {iw, mw, mq, irw, pe, sa, rw, rd, m2r, ill} = '0;
    ps = 2'b00; sb = 2'b00; ac = 3'b010;
    case (s)
      FETCH:    begin mq = 1; sb = 2'b01; irw = mr; pe = mr; end
      DECODE:   begin
        sb  = 2'b11;
        ill = !(o inside {6'b100011, 6'b101011, 6'b000000,
                          6'b000100, 6'b001000, 6'b000010});
      end
      MEMADR:   begin sa = 1; sb = 2'b10; end
      MEMRD:    begin mq = 1; iw = 1; end
      MEMWB:    begin rw = 1; m2r = 1; end
      MEMWR:    begin mq = 1; iw = 1; mw = 1; end
      EXECUTE:  begin
        sa = 1;
        case (f)
          6'b100000: ac = 3'b010;
          6'b100001: ac = 3'b011;
          6'b100010: ac = 3'b110;
          6'b100100: ac = 3'b000;
          6'b100101: ac = 3'b001;
          6'b101010: ac = 3'b111;
          default:   ac = 3'b100;
        endcase
      end
      ALUWB:    begin rw = 1; rd = 1; end
      BRANCH:   begin sa = 1; ac = 3'b110; ps = 2'b01; pe = z; end
      ADDIEXEC: begin sa = 1; sb = 2'b10; end
      ADDIWB:   begin rw = 1; end
      JUMP:     begin ps = 2'b10; pe = 1; end
      default:  ;
    endcase
    return {iw, mw, mq, irw, pe, ps, sa, sb, ac, rw, rd, m2r, ill};
  endfunction

  task automatic chk(input string name, input logic [16:0] got, input logic [16:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, got, want);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk($sformatf("step%0d outputs", mon_e.tag), act, mon_e.o);
      chk($sformatf("step%0d retired", mon_e.tag), 17'(retired), 17'(mon_e.ret));
    end
  end

  task automatic step(input state_t s, input logic z, input logic mr, input bit ret);
    zero = z;
    mem_ready = mr;
    q.push_back('{o: expv(s, op, funct, z, mr), ret: exp_ret, tag: tag[15:0]});
    tag++;
    @(posedge clk); #1;
    if (ret) exp_ret = exp_ret + 1'b1;
  endtask

  task automatic do_rtype(input logic [5:0] fn);
    op = 6'b000000; funct = fn;
    step(FETCH, 0, 1, 0); step(DECODE, 0, 0, 0);
    step(EXECUTE, 1, 0, 0); step(ALUWB, 0, 1, 1);
  endtask

  task automatic do_jump();
    op = 6'b000010; funct = 6'b111111;
    step(FETCH, 0, 1, 0); step(DECODE, 0, 1, 0); step(JUMP, 0, 0, 1);
  endtask

  initial begin
    reset = 1'b0; op = 6'b000000; funct = 6'b000000;
    zero = 1'b0; mem_ready = 1'b0; exp_ret = '0;
    @(posedge clk); #1;
    step(FETCH, 0, 1, 0);
    step(FETCH, 0, 0, 0);
    reset = 1'b1;

    // addi then add
    op = 6'b001000;
    step(FETCH, 0, 1, 0); step(DECODE, 0, 1, 0);
    step(ADDIEXEC, 0, 1, 0); step(ADDIWB, 0, 1, 1);
    do_rtype(6'b100000);
    step(FETCH, 0, 0, 0);
    chk("retired after addi+add", 17'(retired), 17'd2);

    // lw with fetch stall and three MEMRD stalls
    op = 6'b100011;
    step(FETCH, 0, 0, 0); step(FETCH, 0, 1, 0); step(DECODE, 0, 0, 0);
    step(MEMADR, 0, 1, 0);
    step(MEMRD, 0, 0, 0); step(MEMRD, 0, 0, 0); step(MEMRD, 0, 0, 0);
    step(MEMRD, 0, 1, 0); step(MEMWB, 0, 0, 1);

    // sw with one write stall
    op = 6'b101011;
    step(FETCH, 0, 1, 0); step(DECODE, 0, 1, 0); step(MEMADR, 0, 0, 0);
    step(MEMWR, 0, 0, 0); step(MEMWR, 0, 1, 1);

    // beq taken and not taken
    op = 6'b000100;
    step(FETCH, 0, 1, 0); step(DECODE, 1, 1, 0); step(BRANCH, 1, 0, 1);
    step(FETCH, 1, 1, 0); step(DECODE, 1, 1, 0); step(BRANCH, 0, 1, 1);

    // remaining functs plus an unsupported one
    do_rtype(6'b100001); do_rtype(6'b100010); do_rtype(6'b100100);
    do_rtype(6'b100101); do_rtype(6'b101010); do_rtype(6'b000111);

    // illegal opcode: pulse in DECODE, no retire
    op = 6'b111111;
    step(FETCH, 0, 1, 0); step(DECODE, 0, 1, 0);
    op = 6'b000000;
    step(FETCH, 0, 0, 0);

    // reset during a stalled MEMWR
    op = 6'b101011;
    step(FETCH, 0, 1, 0); step(DECODE, 0, 1, 0); step(MEMADR, 0, 1, 0);
    zero = 1'b0; mem_ready = 1'b0;
    q.push_back('{o: expv(MEMWR, op, funct, 0, 0), ret: exp_ret, tag: tag[15:0]});
    tag++;
    @(negedge clk); #1;
    reset = 1'b0; #1;
    chk("mem_write after async reset", 17'(mem_write), 17'd0);
    chk("outputs after async reset", act, expv(FETCH, op, funct, 0, 0));
    chk("retired after async reset", 17'(retired), 17'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    exp_ret = '0;
    step(FETCH, 0, 0, 0);

    // 17 jumps with a 4-bit counter wrap to 1
    for (int i = 0; i < 17; i++) do_jump();
    op = 6'b000000;
    step(FETCH, 0, 0, 0);
    chk("retired wrap", 17'(retired), 17'd1);

    repeat (2) @(posedge clk);
    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL scoreboard drain: %0d entries left, expected 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Multicycle sequencer for the MIPS-subset datapath: one shared memory for instructions and data, one shared ALU, and instruction/data holding registers between steps.
- Decodes op and funct from the instruction register.
- Walks a Moore FSM that drives every datapath mux and enable, one step per cycle.
- Stalls on a memory ready handshake, flags unsupported opcodes, and counts retired instructions.
- Replaces the single-cycle decoder when the core is built in multicycle form.

Parameters:
RETIRE_W, 32, width of the retired-instruction counter (wraps modulo 2^RETIRE_W)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low; 0 forces the reset state immediately
op  in  6  instruction register bits [31:26]
funct  in  6  instruction register bits [5:0]
zero  in  1  ALU zero flag, current cycle
mem_ready  in  1  memory completes the access this cycle
iord  out  1  memory address select: 0=PC, 1=ALUOut
mem_write  out  1  memory write strobe
mem_req  out  1  memory access requested this cycle
ir_write  out  1  load the instruction register
pc_en  out  1  PC load enable; equals pc_write OR (branch AND zero)
pc_src  out  2  PC source: 00=ALUResult, 01=ALUOut, 10=jump target
alu_src_a  out  1  ALU A select: 0=PC, 1=register A
alu_src_b  out  2  ALU B select: 00=reg B, 01=const 4, 10=SignImm, 11=SignImm<<2
alu_control  out  3  ALU operation code
reg_write  out  1  register file write enable
reg_dst  out  1  register file write address: 1=rd, 0=rt
mem_to_reg  out  1  register file write data: 1=data register, 0=ALUOut
illegal_op  out  1  one-cycle pulse when the opcode is unsupported
retired  out  RETIRE_W  count of completed instructions

Behaviour:
- reset low: state=FETCH, retired=0. All outputs are combinational from the state register; the FETCH encoding applies while reset is held.
- Any output not listed for a state is 0. alu_control defaults to 010 (add).
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, pc_src=00.
  - mem_ready=1: ir_write=1, pc_write=1, go to DECODE.
  - mem_ready=0: stay in FETCH with ir_write=0 and pc_write=0.
- DECODE: alu_src_a=0, alu_src_b=11 (precomputes the branch target). Next state by op:
  - 100011 or 101011 -> MEMADR
  - 000000 -> EXECUTE
  - 000100 -> BRANCH
  - 001000 -> ADDIEXEC
  - 000010 -> JUMP
  - any other op -> illegal_op=1 for this cycle, go to FETCH; retired is not incremented.
- MEMADR: alu_src_a=1, alu_src_b=10. Next state is MEMRD if op=100011, else MEMWR.
- MEMRD: mem_req=1, iord=1. Hold until mem_ready=1, then go to MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1. Go to FETCH.
- MEMWR: mem_req=1, iord=1, mem_write=1. mem_write stays asserted on every waiting cycle. On mem_ready=1 go to FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_control from funct:
  - 100000 -> 010 (add)
  - 100001 -> 011 (mul)
  - 100010 -> 110 (sub)
  - 100100 -> 000 (and)
  - 100101 -> 001 (or)
  - 101010 -> 111 (slt)
  - any other funct -> 100; still proceeds to ALUWB.
  - Next state: ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. Go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_control=110, branch=1, pc_src=01. pc_en=zero. Go to FETCH.
- ADDIEXEC: alu_src_a=1, alu_src_b=10. Go to ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. Go to FETCH.
- JUMP: pc_src=10, pc_write=1. Go to FETCH.
- Retired counter:
  - Increments by 1 on every transition into FETCH from MEMWB, MEMWR (on mem_ready=1), ALUWB, BRANCH, ADDIWB or JUMP.
  - Wraps from all-ones to 0.
- Cycle counts with mem_ready tied high:
  - lw: 5
  - sw, R-type, addi: 4
  - beq, j: 3
  - Each stall cycle adds 1.
- Reset low mid-instruction: FSM returns to FETCH asynchronously; no write strobe is emitted after reset falls.
- mem_ready is ignored in every state that does not assert mem_req.

Decomposition:
- Shared package mc_pkg holds:
  - state enum (FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP)
  - opcode constants
  - funct constants
  - alu_control encodings
  - alu_src_b and pc_src encodings
- One combinational sub-module, mc_alu_decoder, maps funct to alu_control.
- The FSM, output decode and counter stay in mc_control_unit.

Test Plan:
- mem_ready=1, sequence op=001000 then 000000/funct=100000 -> states FETCH,DECODE,ADDIEXEC,ADDIWB,FETCH,DECODE,EXECUTE,ALUWB; retired=2 after 8 cycles; reg_write high exactly in cycles 4 and 8.
- lw with mem_ready low for 3 cycles in MEMRD -> MEMRD held 4 cycles with mem_req=1, iord=1; MEMWB reached on cycle 9; mem_to_reg=1 there.
- beq: once with zero=1, once with zero=0 -> pc_en=1 and 0 respectively in the BRANCH cycle; pc_src=01 and alu_control=110 in both cases; each takes 3 cycles.
- op=111111 -> illegal_op pulses in the DECODE cycle; FSM is back in FETCH next cycle; retired unchanged.
- Assert reset low during MEMWR with mem_ready=0 -> mem_write drops in the same cycle; after reset releases, state=FETCH and retired=0.
- RETIRE_W=4: retire 17 j instructions -> retired=1 (wrap); each j shows pc_src=10 and pc_en=1 in the JUMP cycle.
